// File: rtl/ab_link_arbiter_pkg.sv
// ab_arb_pkg: shared types, defaults and helpers for the a/b link arbiter
package ab_arb_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} ab_arb_state_e;
  localparam int AB_N_REQ = 2;
  localparam int AB_LEN_W = 4;
  function automatic int unsigned ab_eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction
endpackage

// File: rtl/ab_link_arbiter_if.sv
// ab_link_arbiter_if: requester handshake plus the shared a/b link
interface ab_link_arbiter_if
  import ab_arb_pkg::*;
#(
  parameter int N_REQ = AB_N_REQ,
  parameter int LEN_W = AB_LEN_W
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][LEN_W-1:0] req_len;
  logic [N_REQ-1:0]            req_val;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            done;
  logic                        rsp_b;
  logic                        a;
  logic                        b;
  logic                        busy;
  modport master (output req, req_len, req_val, b, input gnt, done, rsp_b, a, busy);
  modport slave  (input req, req_len, req_val, b, output gnt, done, rsp_b, a, busy);
endinterface

// File: rtl/ab_link_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting one past ptr
module rr_picker #(
  parameter int N_REQ = 2,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic             valid
);
  logic [PW-1:0] idx;
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (win == '0 && req[idx]) win[idx] = 1'b1;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/ab_link_arbiter.sv
// ab_link_arbiter: round-robin sequencer sharing one a/b link among requesters
module ab_link_arbiter
  import ab_arb_pkg::*;
#(
  parameter int N_REQ = AB_N_REQ,
  parameter int LEN_W = AB_LEN_W
) (
  input logic clk,
  input logic rst,
  ab_link_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  ab_arb_state_e state, state_d;
  logic [PW-1:0] ptr, ptr_d, own, own_d, win_idx;
  logic [LEN_W-1:0] cnt, cnt_d, len_q, len_d;
  logic [N_REQ-1:0] win, gnt_d, done_d;
  logic val_q, val_d, win_vld, a_d, rsp_d;
  rr_picker #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .ptr(ptr), .win(win), .valid(win_vld));
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (win[i]) win_idx = PW'(i);
  end
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    own_d   = own;
    cnt_d   = cnt;
    len_d   = len_q;
    val_d   = val_q;
    gnt_d   = '0;
    done_d  = '0;
    a_d     = 1'b0;
    rsp_d   = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        state_d = DRIVE;
        own_d   = win_idx;
        len_d   = LEN_W'(ab_eff_len(32'(bus.req_len[win_idx])));
        val_d   = bus.req_val[win_idx];
        cnt_d   = '0;
        gnt_d   = win;
        a_d     = bus.req_val[win_idx];
      end
      DRIVE: if (cnt == len_q - 1'b1) begin
        state_d = SAMPLE;
        rsp_d   = bus.b;
        done_d  = N_REQ'(1) << own;
      end else begin
        cnt_d = cnt + 1'b1;
        a_d   = val_q;
      end
      SAMPLE: begin
        state_d = IDLE;
        ptr_d   = own;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PW'(N_REQ - 1);
      own       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      val_q     <= 1'b0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.rsp_b <= 1'b0;
      bus.a     <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      own       <= own_d;
      cnt       <= cnt_d;
      len_q     <= len_d;
      val_q     <= val_d;
      bus.gnt   <= gnt_d;
      bus.done  <= done_d;
      bus.rsp_b <= rsp_d;
      bus.a     <= a_d;
      bus.busy  <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_ab_link_arbiter.sv
// tb_ab_link_arbiter: directed and random stimulus against a cycle-schedule model
module tb_ab_link_arbiter;
  localparam int N = 2;
  localparam int LW = 4;
  localparam int NC = 4000;
  logic clk = 1'b0;
  logic rst;
  ab_link_arbiter_if #(.N_REQ(N), .LEN_W(LW)) bus ();
  ab_link_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit [N-1:0] exp_gnt[NC], exp_done[NC];
  bit exp_a[NC], exp_busy[NC], b_hist[NC];
  int rsp_src[NC];
  int cyc, free_at, m_ptr, n_vec, n_err;
  bit pending[N];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask
  // Expected outputs are scheduled per cycle from the documented timing when a pick happens.
  task automatic model_eval();
    int w, len;
    b_hist[cyc] = bus.b;
    if (rst) begin
      for (int k = cyc + 1; k < cyc + 40; k++) begin
        exp_gnt[k] = '0; exp_done[k] = '0; exp_a[k] = 0; exp_busy[k] = 0;
      end
      m_ptr = N - 1;
      free_at = cyc + 1;
    end else if (cyc >= free_at && |bus.req) begin
      w = -1;
      for (int i = 1; i <= N; i++)
        if (w < 0 && bus.req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      len = (bus.req_len[w] == 0) ? 1 : int'(bus.req_len[w]);
      exp_gnt[cyc + 1] = N'(1) << w;
      for (int k = 1; k <= len; k++) exp_a[cyc + k] = bus.req_val[w];
      for (int k = 1; k <= len + 1; k++) exp_busy[cyc + k] = 1;
      exp_done[cyc + len + 1] = N'(1) << w;
      rsp_src[cyc + len + 1] = cyc + len;
      m_ptr = w;
      free_at = cyc + len + 2;
    end
  endtask
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt[cyc]));
    chk("done", 32'(bus.done), 32'(exp_done[cyc]));
    chk("a", 32'(bus.a), 32'(exp_a[cyc]));
    chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
    chk("rsp_b", 32'(bus.rsp_b), (exp_done[cyc] != 0) ? 32'(b_hist[rsp_src[cyc]]) : 32'd0);
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic set_req(input int r, input bit on, input int len, input bit val);
    bus.req[r] = on;
    bus.req_len[r] = LW'(len);
    bus.req_val[r] = val;
  endtask
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_len = '0;
    bus.req_val = '0;
    bus.b = 1'b0;
    m_ptr = N - 1;
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;
    idle(2);
    set_req(0, 1, 3, 1); bus.b = 1'b1;
    step();
    set_req(0, 0, 0, 0);
    idle(6);
    set_req(0, 1, 1, 1); set_req(1, 1, 1, 0);
    idle(12);
    bus.req = '0;
    idle(4);
    set_req(1, 1, 0, 1);
    step();
    set_req(1, 0, 0, 0);
    idle(4);
    set_req(0, 1, 2, 0); bus.b = 1'b0;
    step();
    set_req(0, 0, 0, 0);
    step();
    bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    idle(4);
    set_req(0, 1, 2, 1);
    step();
    set_req(0, 0, 0, 0); bus.b = 1'b1;
    step();
    bus.b = 1'b0;
    idle(5);
    set_req(0, 1, 8, 1);
    step();
    set_req(0, 0, 0, 0);
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1, 2, 1); set_req(1, 1, 2, 1);
    step();
    set_req(0, 0, 0, 0);
    idle(10);
    set_req(1, 0, 0, 0);
    idle(5);
    set_req(0, 1, 5, 1);
    step();
    set_req(0, 0, 0, 0); set_req(1, 1, 3, 1);
    step();
    set_req(1, 0, 0, 0);
    idle(10);
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++) begin
        if (bus.gnt[r]) pending[r] = 0;
        if (pending[r] && $urandom_range(0, 24) == 0) pending[r] = 0;
        if (pending[r]) continue;
        if ($urandom_range(0, 3) == 0) begin
          pending[r] = 1;
          set_req(r, 1, int'($urandom_range(0, 15)), 1'($urandom));
        end else set_req(r, 0, int'($urandom_range(0, 15)), 1'($urandom));
      end
      bus.b = 1'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    bus.req = '0;
    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ab_link_arbiter.md
# ab_link_arbiter

Round-robin arbiter and sequencer that shares one synchronous a/b link (output `a`, input `b`) between `N_REQ` requesters. Each granted requester gets a drive burst of `a` for a programmed number of cycles, then one sample of `b` that is returned with a done pulse. The block sits between per-requester testbench/control logic and the single DUT-side link, replacing direct per-requester driving of `a`.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (≥2)
- `LEN_W`, 4, width of the burst-length field

Ports:
- `clk`  in  1  clock; all logic on its rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req`  in  N_REQ  per-requester request level
- `req_len`  in  N_REQ×LEN_W  burst length per requester; 0 treated as 1
- `req_val`  in  N_REQ  value to drive on `a` during the burst
- `gnt`  out  N_REQ  one-hot, one-cycle grant pulse
- `done`  out  N_REQ  one-hot, one-cycle completion pulse
- `rsp_b`  out  1  sampled `b`; valid while any `done` is high
- `a`  out  1  shared link output
- `b`  in  1  shared link input
- `busy`  out  1  high in DRIVE and SAMPLE

## Operation
- Every output is registered. In reset and IDLE: `gnt`=0, `done`=0, `rsp_b`=0, `a`=0, `busy`=0.
- FSM states:
  - **IDLE**: if any `req` is set, select the winner by round-robin and latch its `req_len` and `req_val`. Pulse `gnt[w]`, then go to DRIVE. If no `req` is set, stay in IDLE.
  - **DRIVE**: `a` = latched value; the counter counts burst cycles. After the last cycle, capture `b` into `rsp_b` and go to SAMPLE.
  - **SAMPLE**: `done[w]` = 1 and `a` = 0. Set the round-robin pointer to `w`, then go to IDLE.
- Round-robin search starts at pointer+1 and wraps modulo `N_REQ`. After reset the pointer is `N_REQ-1`, so requester 0 has top priority.
- Requester protocol:
  - Hold `req`, `req_len` and `req_val` stable until `gnt`.
  - Inputs may change after `gnt`, because they are latched.
  - Deasserting `req` before `gnt` withdraws the request.
  - `req` asserted by the current owner during its own burst is only considered in the next IDLE.
- Width rule: an effective length of 0 becomes 1. The burst counter is `LEN_W` bits and counts up to `len-1`, with no overflow. The maximum burst is `2^LEN_W - 1` cycles.

## Timing
- `req` sampled in IDLE at cycle t gives:
  - cycle t+1: `gnt` high and the first DRIVE cycle with `a` = `req_val`;
  - cycles t+1 … t+L: `a` driven (L = effective length);
  - cycle t+L+1: SAMPLE, with `done` high, `rsp_b` = `b` as seen during cycle t+L, and `a` = 0;
  - cycle t+L+2: IDLE; the earliest next `gnt` is t+L+3.
- Grant latency is 1 cycle. Request-to-done latency is L+1 cycles.
- Simultaneous requests: exactly one grant per IDLE visit, so there are no back-to-back bursts without an IDLE cycle.
- `rst` asserted mid-burst: the next cycle has `a`=0, no `done` (the transaction is dropped silently), the pointer is reset, and the FSM is in IDLE.
- `req` changing on the same cycle as `gnt` has no effect on the latched transaction.

## Structure
- Package `ab_arb_pkg`:
  - state enum `ab_arb_state_e` {IDLE, DRIVE, SAMPLE};
  - default constants `AB_N_REQ`=2 and `AB_LEN_W`=4;
  - helper function for effective length (0→1).
- Sub-module `rr_picker`: combinational round-robin. Inputs are the request vector and pointer; outputs are a one-hot winner and a `valid` flag. It is parameterised by `N_REQ` and reused by the other arbiters.
- Top level: FSM, burst counter, latched owner/value/length, output registers.

## Test plan
- Single request: `req[0]`=1, `req_len[0]`=3, `req_val[0]`=1, `b`=1 → `gnt[0]` at t+1, `a`=1 for 3 cycles, `done[0]` at t+4 with `rsp_b`=1, `a`=0.
- Contention: `req`=2'b11 held, both lengths 1 → grant order 0,1,0,1; each `done` matches its grant; the spacing between grants is 3 cycles.
- Zero length: `req_len[1]`=0, `req_val[1]`=1 → `a`=1 for exactly 1 cycle and `done[1]` on the next cycle.
- Sample point: `req_len`=2, `b` toggles 0→1 at the second DRIVE cycle → `rsp_b`=1. With `b`=1 only on the first DRIVE cycle, `rsp_b`=0.
- Reset mid-burst: `req_len`=8, assert `rst` at the 4th DRIVE cycle → `a`=0 on the next cycle, no `done`, and the next grant with both requesting goes to requester 0.
- Withdrawal: `req[1]` pulsed while requester 0 is busy, then dropped before IDLE → no `gnt[1]`, and `a` stays 0 after requester 0 completes.
